// File: rtl/instr_mem_responder.sv
// Direct-mapped instruction cache answering IFStage fetches.
// Misses are filled one word at a time from a req/ready backing store.
module instr_mem_responder #(
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc,
    input  logic             inv,
    output logic             hit,
    output logic [31:0]      instr_word,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_ready,
    input  logic [31:0]      mem_rdata,
    output logic             busy,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int LINES = 2 ** IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL
    } state_t;

    state_t state;
    state_t stateNext;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tagArr [LINES];
    logic [31:0]      dataArr[LINES];

    logic [31:0]      missAddr;
    logic [31:0]      fillData;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] pcTag;
    logic [IDX_W-1:0] fillIdx;
    logic [TAG_W-1:0] fillTag;
    logic             lookupHit;
    logic [1:0]       unusedPcBits;

    assign idx          = pc[IDX_W+1:2];
    assign pcTag        = pc[31:IDX_W+2];
    assign fillIdx      = missAddr[IDX_W+1:2];
    assign fillTag      = missAddr[31:IDX_W+2];
    assign unusedPcBits = pc[1:0];

    assign lookupHit  = (state == IDLE) && valid[idx] && (tagArr[idx] == pcTag);
    assign hit        = lookupHit;
    assign instr_word = lookupHit ? dataArr[idx] : 32'h0;
    assign mem_req    = (state == REQ);
    assign mem_addr   = (state == REQ) ? missAddr : 32'h0;
    assign busy       = (state != IDLE);

    // Next-state decode: a miss in IDLE starts a fill, which always completes.
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (!lookupHit) stateNext = REQ;
            REQ:     if (mem_ready) stateNext = FILL;
            FILL:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Latch the miss address on entry to REQ and the fill word on ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            missAddr <= 32'h0;
        end else begin
            if (state == IDLE && !lookupHit) begin
                missAddr <= {pc[31:2], 2'b00};
            end
            if (state == REQ && mem_ready) begin
                fillData <= mem_rdata;
            end
        end
    end

    // Valid bits: invalidate beats a same-cycle fill.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else if (inv) begin
            valid <= '0;
        end else if (state == FILL) begin
            valid[fillIdx] <= 1'b1;
        end
    end

    // Tag and data storage, overwritten unconditionally on fill.
    always_ff @(posedge clk) begin
        if (!reset && state == FILL) begin
            tagArr[fillIdx]  <= fillTag;
            dataArr[fillIdx] <= fillData;
        end
    end

    // Saturating hit/miss statistics, sampled only while IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == IDLE) begin
            if (lookupHit) begin
                if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
            end else begin
                if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboard bench for instr_mem_responder.
// A second instance with CNT_W=4 runs in lockstep to exercise saturation.
module tb_instr_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        inv;
    logic        memReady;
    logic [31:0] pc;
    logic [31:0] memRdata;

    logic        hit, memReq, busy;
    logic [31:0] instrWord, memAddr;
    logic [15:0] hitCnt, missCnt;

    logic        hit2, memReq2, busy2;
    logic [31:0] instrWord2, memAddr2;
    logic [3:0]  hitCnt2, missCnt2;

    int checks = 0;
    int failures = 0;
    int expHit = 0;
    int expMiss = 0;
    logic [31:0] sbQ[$];

    instr_mem_responder dut (
        .clk(clk), .reset(reset), .pc(pc), .inv(inv),
        .hit(hit), .instr_word(instrWord),
        .mem_req(memReq), .mem_addr(memAddr),
        .mem_ready(memReady), .mem_rdata(memRdata),
        .busy(busy), .hit_cnt(hitCnt), .miss_cnt(missCnt)
    );

    instr_mem_responder #(.IDX_W(4), .CNT_W(4)) dutSat (
        .clk(clk), .reset(reset), .pc(pc), .inv(inv),
        .hit(hit2), .instr_word(instrWord2),
        .mem_req(memReq2), .mem_addr(memAddr2),
        .mem_ready(memReady), .mem_rdata(memRdata),
        .busy(busy2), .hit_cnt(hitCnt2), .miss_cnt(missCnt2)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input logic [31:0] a);
        logic [31:0] w;
        w = {a[15:0] ^ 16'hBEEF, a[15:0] ^ 16'h1357};
        if (a == 32'h100) w = 32'h1234_5678;
        return w;
    endfunction

    function automatic int sat4(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic popCheck(input string name);
        logic [31:0] e;
        @(negedge clk);
        checks++;
        if (sbQ.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            e = sbQ.pop_front();
            if (hit !== 1'b1 || instrWord !== e) begin
                failures++;
                $display("FAIL %s pc=%h hit=%b word=%h exp hit=1 word=%h",
                         name, pc, hit, instrWord, e);
            end
        end
    endtask

    // Starts in the first REQ cycle for line a; ready after k more cycles.
    task automatic finishFill(input logic [31:0] a, input int k);
        @(negedge clk);
        checks++;
        if (memReq !== 1'b1 || memAddr !== a || busy !== 1'b1 || hit !== 1'b0) begin
            failures++;
            $display("FAIL req_phase req=%b addr=%h busy=%b hit=%b exp req=1 addr=%h busy=1 hit=0",
                     memReq, memAddr, busy, hit, a);
        end
        repeat (k) cyc();
        memReady = 1'b1;
        memRdata = model(a);
        cyc();
        memReady = 1'b0;
        memRdata = $urandom;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || memReq !== 1'b0 || hit !== 1'b0 || instrWord !== 32'h0) begin
            failures++;
            $display("FAIL fill_phase busy=%b req=%b hit=%b word=%h exp busy=1 req=0 hit=0 word=0",
                     busy, memReq, hit, instrWord);
        end
        cyc();
        popCheck("fill_hit");
        cyc();
        expHit++;
    endtask

    task automatic doMiss(input logic [31:0] a, input int k);
        pc = a;
        @(negedge clk);
        checks++;
        if (hit !== 1'b0 || instrWord !== 32'h0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL lookup_miss pc=%h hit=%b word=%h busy=%b exp 0 0 0",
                     a, hit, instrWord, busy);
        end
        sbQ.push_back(model(a));
        expMiss++;
        cyc();
        finishFill(a, k);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        inv = 1'b0;
        memReady = 1'b0;
        memRdata = 32'h0;
        pc = 32'h0;
        cyc();
        cyc();
        @(negedge clk);
        checks++;
        if (hit !== 1'b0 || instrWord !== 32'h0 || busy !== 1'b0 ||
            memReq !== 1'b0 || memAddr !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs hit=%b word=%h busy=%b req=%b addr=%h exp all 0",
                     hit, instrWord, busy, memReq, memAddr);
        end
        checks++;
        if (hitCnt !== 16'h0 || missCnt !== 16'h0 || hitCnt2 !== 4'h0) begin
            failures++;
            $display("FAIL reset_counters hit_cnt=%h miss_cnt=%h hit_cnt4=%h exp 0",
                     hitCnt, missCnt, hitCnt2);
        end
        cyc();
    endtask

    task automatic test_cold_miss();
        reset = 1'b0;
        doMiss(32'h100, 3);
        @(negedge clk);
        checks++;
        if (missCnt !== 16'(expMiss) || expMiss != 1) begin
            failures++;
            $display("FAIL cold_miss_cnt got=%0d exp=1", missCnt);
        end
        cyc();
        expHit++;
    endtask

    task automatic test_hit_run();
        for (int i = 0; i < 10; i++) begin
            sbQ.push_back(model(32'h100));
            popCheck("hit_run");
            cyc();
            expHit++;
        end
        pc = 32'h103;
        sbQ.push_back(model(32'h100));
        popCheck("pc_low_bits_ignored");
        checks++;
        if (hitCnt !== 16'(expHit) || memReq !== 1'b0) begin
            failures++;
            $display("FAIL hit_run_cnt hit_cnt=%0d req=%b exp hit_cnt=%0d req=0",
                     hitCnt, memReq, expHit);
        end
        cyc();
        expHit++;
    endtask

    task automatic test_conflict();
        doMiss(32'h000, 1);
        doMiss(32'h040, 0);
        sbQ.push_back(model(32'h040));
        popCheck("conflict_new_hits");
        cyc();
        expHit++;
        doMiss(32'h000, 2);
        @(negedge clk);
        checks++;
        if (missCnt !== 16'(expMiss)) begin
            failures++;
            $display("FAIL conflict_miss_cnt got=%0d exp=%0d", missCnt, expMiss);
        end
        cyc();
        expHit++;
    endtask

    task automatic test_pc_change();
        pc = 32'h008;
        @(negedge clk);
        checks++;
        if (hit !== 1'b0) begin
            failures++;
            $display("FAIL pcchg_miss hit=%b exp 0", hit);
        end
        expMiss++;
        cyc();
        pc = 32'h00C;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (memReq !== 1'b1 || memAddr !== 32'h008) begin
                failures++;
                $display("FAIL pcchg_addr_stable req=%b addr=%h exp req=1 addr=00000008",
                         memReq, memAddr);
            end
            if (i == 0) cyc();
        end
        memReady = 1'b1;
        memRdata = model(32'h008);
        cyc();
        memReady = 1'b0;
        cyc();
        doMiss(32'h00C, 1);
        pc = 32'h008;
        sbQ.push_back(model(32'h008));
        popCheck("pcchg_first_line");
        cyc();
        expHit++;
        pc = 32'h00C;
        sbQ.push_back(model(32'h00C));
        popCheck("pcchg_second_line");
        cyc();
        expHit++;
    endtask

    task automatic test_inv();
        pc = 32'h020;
        @(negedge clk);
        expMiss++;
        cyc();
        memReady = 1'b1;
        memRdata = model(32'h020);
        cyc();
        memReady = 1'b0;
        inv = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || hit !== 1'b0) begin
            failures++;
            $display("FAIL inv_fill_phase busy=%b hit=%b exp busy=1 hit=0", busy, hit);
        end
        cyc();
        inv = 1'b0;
        doMiss(32'h020, 0);
        doMiss(32'h008, 0);
        pc = 32'h020;
        inv = 1'b1;
        sbQ.push_back(model(32'h020));
        popCheck("inv_idle_same_cycle");
        cyc();
        expHit++;
        inv = 1'b0;
        doMiss(32'h020, 0);
        doMiss(32'h008, 0);
    endtask

    task automatic test_reset_mid_req();
        pc = 32'h030;
        @(negedge clk);
        expMiss++;
        cyc();
        @(negedge clk);
        checks++;
        if (memReq !== 1'b1 || memAddr !== 32'h030) begin
            failures++;
            $display("FAIL pre_reset_req req=%b addr=%h exp req=1 addr=00000030",
                     memReq, memAddr);
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        memReady = 1'b1;
        memRdata = 32'hDEAD_BEEF;
        pc = 32'h020;
        expHit = 0;
        expMiss = 0;
        @(negedge clk);
        checks++;
        if (memReq !== 1'b0 || memAddr !== 32'h0 || busy !== 1'b0 ||
            hit !== 1'b0 || instrWord !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_req req=%b addr=%h busy=%b hit=%b word=%h exp all 0",
                     memReq, memAddr, busy, hit, instrWord);
        end
        checks++;
        if (hitCnt !== 16'h0 || missCnt !== 16'h0 || hitCnt2 !== 4'h0 || missCnt2 !== 4'h0) begin
            failures++;
            $display("FAIL reset_mid_cnt hit=%h miss=%h hit4=%h miss4=%h exp 0",
                     hitCnt, missCnt, hitCnt2, missCnt2);
        end
        cyc();
        memReady = 1'b0;
        expMiss = 1;
        sbQ.push_back(model(32'h020));
        finishFill(32'h020, 1);
        for (int i = 0; i < 20; i++) begin
            sbQ.push_back(model(32'h020));
            popCheck("sat_run");
            cyc();
            expHit++;
        end
        @(negedge clk);
        checks++;
        if (hitCnt !== 16'(expHit) || missCnt !== 16'(expMiss)) begin
            failures++;
            $display("FAIL post_reset_cnt hit=%0d miss=%0d exp hit=%0d miss=%0d",
                     hitCnt, missCnt, expHit, expMiss);
        end
        checks++;
        if (hitCnt2 !== 4'(sat4(expHit)) || missCnt2 !== 4'(sat4(expMiss))) begin
            failures++;
            $display("FAIL sat_cnt4 hit=%0d miss=%0d exp hit=%0d miss=%0d",
                     hitCnt2, missCnt2, sat4(expHit), sat4(expMiss));
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit_run();
        test_conflict();
        test_pc_change();
        test_inv();
        test_reset_mid_req();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
